uart_tx_buffer: RTL and testbench

Byte buffer and launch sequencer sitting directly upstream of the UART transmitter.
- Accepts bytes from a producer over a valid/ready handshake and stores them in a FIFO.
- Launches each stored byte into the transmitter with a one-cycle start pulse, then waits for the transmitter's txdone pulse.
- Enforces an inter-frame gap and a watchdog timeout, so a stalled transmitter cannot hang the producer forever.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_buffer_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_buffer.sv | 146 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: data width, TX buffer state encoding and default timing.
package uart_pkg;

    localparam int unsigned UART_DATA_W            = 8;
    localparam int unsigned TXB_GAP_CYCLES_DEF     = 4;
    localparam int unsigned TXB_TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [1:0] {
        TXB_IDLE   = 2'd0,
        TXB_LAUNCH = 2'd1,
        TXB_BUSY   = 2'd2,
        TXB_GAP    = 2'd3
    } txb_state_e;

endpackage

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// TX byte buffer: FIFO plus launch sequencer with inter-frame gap and BUSY watchdog.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned GAP_CYCLES     = TXB_GAP_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TXB_TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   uart_start,
    output logic [UART_DATA_W-1:0] uart_txin,
    input  logic                   uart_txdone,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   err_sticky
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP_CYCLES - 1);

    txb_state_e             state_q, state_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic [GP_W-1:0]        gap_q, gap_d;
    logic                   start_q, start_d;
    logic [UART_DATA_W-1:0] txin_q, txin_d;
    logic                   tout_q, tout_d;
    logic                   sticky_q, sticky_d;
    logic                   fifo_push, fifo_pop;
    logic [UART_DATA_W-1:0] fifo_rdata;
    logic                   leave_busy, end_wait;

    assign in_ready    = !full && !rst;
    assign fifo_push   = in_valid && in_ready;
    assign busy        = (state_q != TXB_IDLE);
    assign uart_start  = start_q;
    assign uart_txin   = txin_q;
    assign timeout_err = tout_q;
    assign err_sticky  = sticky_q;

    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // End of a wait (gap done, or BUSY exit with no gap) pops the next byte directly,
    // so the next start follows txdone by GAP_CYCLES+2 cycles.
    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
        start_d    = 1'b0;
        txin_d     = txin_q;
        tout_d     = 1'b0;
        sticky_d   = sticky_q;
        fifo_pop   = 1'b0;
        leave_busy = 1'b0;
        end_wait   = 1'b0;
        case (state_q)
            TXB_IDLE: begin
                if (!empty) begin
                    fifo_pop = 1'b1;
                    txin_d   = fifo_rdata;
                    state_d  = TXB_LAUNCH;
                end
            end
            TXB_LAUNCH: begin
                start_d = 1'b1;
                wdog_d  = '0;
                state_d = TXB_BUSY;
            end
            TXB_BUSY: begin
                if (uart_txdone) begin
                    leave_busy = 1'b1;
                end else if (wdog_q == WD_LAST) begin
                    leave_busy = 1'b1;
                    tout_d     = 1'b1;
                    sticky_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            TXB_GAP: begin
                if (gap_q == GP_LAST) end_wait = 1'b1;
                else                  gap_d    = gap_q + GP_W'(1);
            end
            default: state_d = TXB_IDLE;
        endcase
        if (leave_busy) begin
            if (GAP_CYCLES == 0) begin
                end_wait = 1'b1;
            end else begin
                state_d = TXB_GAP;
                gap_d   = '0;
            end
        end
        if (end_wait) begin
            if (!empty) begin
                fifo_pop = 1'b1;
                txin_d   = fifo_rdata;
                state_d  = TXB_LAUNCH;
            end else begin
                state_d = TXB_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= TXB_IDLE;
            wdog_q   <= '0;
            gap_q    <= '0;
            start_q  <= 1'b0;
            txin_q   <= '0;
            tout_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            gap_q    <= gap_d;
            start_q  <= start_d;
            txin_q   <= txin_d;
            tout_q   <= tout_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: three parameterisations sharing stimulus, one selected at a time.
module tb_uart_tx_buffer;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       stray = 1'b0;
    logic       tx_pulse = 1'b0;
    int         cyc = 0;
    int         tx_lat = 0;
    int         tx_cnt = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         log_cyc[$];
    logic [7:0] log_dat[$];

    logic [2:0] vld_v, done_v, ready_v, start_v, empty_v, full_v, busy_v, tout_v, sticky_v;
    logic [7:0] txin_v [3];
    logic [4:0] lvl0, lvl1;
    logic [2:0] lvl2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            vld_v[i]  = in_valid && (sel == 2'(i));
            done_v[i] = (tx_pulse || stray) && (sel == 2'(i));
        end
    end

    uart_tx_buffer #(.DEPTH(16), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(4096)) u_def (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld_v[0]), .in_ready(ready_v[0]),
        .uart_start(start_v[0]), .uart_txin(txin_v[0]), .uart_txdone(done_v[0]), .level(lvl0),
        .empty(empty_v[0]), .full(full_v[0]), .busy(busy_v[0]), .timeout_err(tout_v[0]),
        .err_sticky(sticky_v[0]));

    uart_tx_buffer #(.DEPTH(16), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(64)) u_to (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld_v[1]), .in_ready(ready_v[1]),
        .uart_start(start_v[1]), .uart_txin(txin_v[1]), .uart_txdone(done_v[1]), .level(lvl1),
        .empty(empty_v[1]), .full(full_v[1]), .busy(busy_v[1]), .timeout_err(tout_v[1]),
        .err_sticky(sticky_v[1]));

    uart_tx_buffer #(.DEPTH(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(4096)) u_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(vld_v[2]), .in_ready(ready_v[2]),
        .uart_start(start_v[2]), .uart_txin(txin_v[2]), .uart_txdone(done_v[2]), .level(lvl2),
        .empty(empty_v[2]), .full(full_v[2]), .busy(busy_v[2]), .timeout_err(tout_v[2]),
        .err_sticky(sticky_v[2]));

    // Transmitter model (txdone tx_lat cycles after each start) and start-pulse logger.
    always @(negedge clk) begin
        tx_pulse = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt = tx_cnt - 1;
            if (tx_cnt == 0) tx_pulse = 1'b1;
        end
        if (start_v[sel]) begin
            log_cyc.push_back(cyc);
            log_dat.push_back(txin_v[sel]);
            if (tx_lat > 0) tx_cnt = tx_lat;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (ready_v !== 3'b000) begin
            miscompares++; $display("FAIL reset_in_ready: got %b expected 000", ready_v);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({ready_v[i], empty_v[i], full_v[i], start_v[i], busy_v[i], tout_v[i], sticky_v[i]} !== 7'b1100000) begin
                miscompares++;
                $display("FAIL reset_flags[%0d]: got rdy/emp/full/start/busy/tout/stk=%b%b%b%b%b%b%b expected 1100000",
                         i, ready_v[i], empty_v[i], full_v[i], start_v[i], busy_v[i], tout_v[i], sticky_v[i]);
            end
            vectors++;
            if (txin_v[i] !== 8'h00) begin
                miscompares++; $display("FAIL reset_txin[%0d]: got %h expected 00", i, txin_v[i]);
            end
        end
        vectors++;
        if ({lvl0, lvl1, lvl2} !== 13'd0) begin
            miscompares++; $display("FAIL reset_level: got %0d %0d %0d expected 0", lvl0, lvl1, lvl2);
        end
    endtask

    task automatic test_single();
        int n, s, c;
        sel = 2'd0; tx_lat = 100;
        log_cyc.delete(); log_dat.delete();
        @(negedge clk);
        n = cyc;
        vectors++;
        if (ready_v[0] !== 1'b1) begin
            miscompares++; $display("FAIL single_ready: got %b expected 1", ready_v[0]);
        end
        in_data = 8'hA5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        s = n + 3;
        c = s + 100;
        while (cyc < c + 8) begin
            if (cyc >= s && cyc <= c) begin
                vectors++;
                if (txin_v[0] !== 8'hA5) begin
                    miscompares++; $display("FAIL single_txin @%0d: got %h expected a5", cyc, txin_v[0]);
                end
            end
            if (cyc == c + GAP) begin
                vectors++;
                if (busy_v[0] !== 1'b1) begin
                    miscompares++; $display("FAIL single_busy_gap: got %b expected 1", busy_v[0]);
                end
            end
            if (cyc == c + GAP + 1) begin
                vectors++;
                if (busy_v[0] !== 1'b0 || lvl0 !== 5'd0 || empty_v[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_idle: got busy=%b level=%0d empty=%b expected 0/0/1", busy_v[0], lvl0, empty_v[0]);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (log_cyc.size() != 1) begin
            miscompares++; $display("FAIL single_start_count: got %0d expected 1", log_cyc.size());
        end else begin
            vectors++;
            if (log_cyc[0] != s || log_dat[0] !== 8'hA5) begin
                miscompares++;
                $display("FAIL single_start: got cyc %0d data %h expected cyc %0d data a5", log_cyc[0], log_dat[0], s);
            end
        end
        tx_lat = 0;
    endtask

    task automatic test_timeout();
        int n0, s;
        sel = 2'd1; tx_lat = 0;
        log_cyc.delete(); log_dat.delete();
        @(negedge clk);
        n0 = cyc;
        for (int b = 1; b <= 17; b++) begin
            vectors++;
            if (ready_v[1] !== 1'b1) begin
                miscompares++; $display("FAIL fill_ready byte %0d: got %b expected 1", b, ready_v[1]);
            end
            in_data = 8'(b); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        s = n0 + 3;
        vectors++;
        if (full_v[1] !== 1'b1 || ready_v[1] !== 1'b0 || lvl1 !== 5'd16) begin
            miscompares++;
            $display("FAIL fill_full: got full=%b ready=%b level=%0d expected 1/0/16", full_v[1], ready_v[1], lvl1);
        end
        while (cyc <= s + 72) begin
            vectors++;
            if (tout_v[1] !== (cyc == s + 64)) begin
                miscompares++; $display("FAIL timeout_pulse @%0d: got %b expected %b", cyc, tout_v[1], cyc == s + 64);
            end
            vectors++;
            if (sticky_v[1] !== (cyc >= s + 64)) begin
                miscompares++; $display("FAIL err_sticky @%0d: got %b expected %b", cyc, sticky_v[1], cyc >= s + 64);
            end
            if (cyc == s + 69) begin
                vectors++;
                if (lvl1 !== 5'd15 || full_v[1] !== 1'b0) begin
                    miscompares++; $display("FAIL post_timeout_level: got %0d full=%b expected 15/0", lvl1, full_v[1]);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (log_cyc.size() != 2) begin
            miscompares++; $display("FAIL timeout_start_count: got %0d expected 2", log_cyc.size());
        end else begin
            vectors++;
            if (log_cyc[0] != s || log_dat[0] !== 8'h01 || log_cyc[1] != s + 69 || log_dat[1] !== 8'h02) begin
                miscompares++;
                $display("FAIL timeout_starts: got %0d:%h %0d:%h expected %0d:01 %0d:02",
                         log_cyc[0], log_dat[0], log_cyc[1], log_dat[1], s, s + 69);
            end
        end
    endtask

    task automatic test_reset_busy();
        sel = 2'd0; tx_lat = 0;
        log_cyc.delete(); log_dat.delete();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy_v[0] !== 1'b1 || lvl0 !== 5'd3 || sticky_v[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: got busy=%b level=%0d sticky1=%b expected 1/3/1", busy_v[0], lvl0, sticky_v[1]);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready_v !== 3'b000) begin
            miscompares++; $display("FAIL rst_in_ready: got %b expected 000", ready_v);
        end
        vectors++;
        if (lvl0 !== 5'd0 || empty_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || start_v[0] !== 1'b0 || sticky_v[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_frame_reset: got level=%0d empty=%b busy=%b start=%b sticky1=%b expected 0/1/0/0/0",
                     lvl0, empty_v[0], busy_v[0], start_v[0], sticky_v[1]);
        end
        rst = 1'b0; stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (20) begin
            vectors++;
            if (start_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL stray_after_reset: got start=%b busy=%b ready=%b expected 0/0/1", start_v[0], busy_v[0], ready_v[0]);
            end
            @(negedge clk);
        end
        vectors++;
        if (log_cyc.size() != 1) begin
            miscompares++; $display("FAIL reset_start_count: got %0d expected 1", log_cyc.size());
        end
    endtask

    task automatic test_stray();
        int n, s, c;
        logic [7:0] b;
        sel = 2'd0; tx_lat = 20;
        log_cyc.delete(); log_dat.delete();
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (5) begin
            vectors++;
            if (busy_v[0] !== 1'b0 || start_v[0] !== 1'b0 || tout_v[0] !== 1'b0) begin
                miscompares++; $display("FAIL idle_stray: got busy=%b start=%b tout=%b expected 0/0/0", busy_v[0], start_v[0], tout_v[0]);
            end
            @(negedge clk);
        end
        b = 8'($urandom);
        n = cyc;
        in_data = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        s = n + 3;
        c = s + 20;
        while (cyc < c + 10) begin
            stray = (cyc == c + 2);
            vectors++;
            if (start_v[0] !== (cyc == s)) begin
                miscompares++; $display("FAIL gap_stray_start @%0d: got %b expected %b", cyc, start_v[0], cyc == s);
            end
            if (cyc >= s) begin
                vectors++;
                if (busy_v[0] !== (cyc <= c + GAP) || tout_v[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gap_stray_busy @%0d: got busy=%b tout=%b expected %b/0", cyc, busy_v[0], tout_v[0], cyc <= c + GAP);
                end
            end
            @(negedge clk);
        end
        stray = 1'b0;
        vectors++;
        if (log_dat.size() != 1 || log_dat[0] !== b) begin
            miscompares++; $display("FAIL gap_stray_data: got %0d starts expected 1 with data %h", log_dat.size(), b);
        end
        tx_lat = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[$];
        int n, s0, last;
        sel = 2'd0; tx_lat = 50;
        log_cyc.delete(); log_dat.delete();
        for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
        @(negedge clk);
        n = cyc;
        for (int i = 0; i < 8; i++) begin
            in_data = bytes[i]; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        s0 = n + 3;
        last = s0 + 7 * (50 + GAP + 2);
        while (cyc < last + 60) begin
            vectors++;
            if (tout_v[0] !== 1'b0) begin
                miscompares++; $display("FAIL stream_tout @%0d: got 1 expected 0", cyc);
            end
            @(negedge clk);
        end
        vectors++;
        if (log_cyc.size() != 8) begin
            miscompares++; $display("FAIL stream_count: got %0d expected 8", log_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (log_cyc[i] != s0 + i * (50 + GAP + 2) || log_dat[i] !== bytes[i]) begin
                    miscompares++;
                    $display("FAIL stream_byte[%0d]: got cyc %0d data %h expected cyc %0d data %h",
                             i, log_cyc[i], log_dat[i], s0 + i * (50 + GAP + 2), bytes[i]);
                end
            end
        end
        vectors++;
        if (lvl0 !== 5'd0 || busy_v[0] !== 1'b0) begin
            miscompares++; $display("FAIL stream_drain: got level=%0d busy=%b expected 0/0", lvl0, busy_v[0]);
        end
        tx_lat = 0;
    endtask

    task automatic test_wrap();
        logic [7:0] bytes[$];
        int lat, idx, first, budget, s;
        bit saw_full;
        sel = 2'd2;
        lat = int'($urandom_range(9, 3));
        tx_lat = lat;
        idx = 0; first = -1; saw_full = 1'b0;
        log_cyc.delete(); log_dat.delete();
        for (int i = 0; i < 12; i++) bytes.push_back(8'($urandom));
        @(negedge clk);
        budget = 12 * (lat + 2) + 40;
        for (int t = 0; t < budget; t++) begin
            vectors++;
            if (lvl2 > 3'd4) begin
                miscompares++; $display("FAIL wrap_level @%0d: got %0d expected <=4", cyc, lvl2);
            end
            if (lvl2 == 3'd4) begin
                saw_full = 1'b1;
                vectors++;
                if (full_v[2] !== 1'b1 || ready_v[2] !== 1'b0) begin
                    miscompares++; $display("FAIL wrap_full_flags: got full=%b ready=%b expected 1/0", full_v[2], ready_v[2]);
                end
            end
            if (idx < 12) begin
                in_valid = 1'b1;
                in_data  = bytes[idx];
                if (ready_v[2] === 1'b1) begin
                    if (first < 0) first = cyc;
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (!saw_full || idx != 12) begin
            miscompares++; $display("FAIL wrap_progress: got saw_full=%0d pushed=%0d expected 1/12", saw_full, idx);
        end
        vectors++;
        if (log_cyc.size() != 12) begin
            miscompares++; $display("FAIL wrap_count: got %0d expected 12", log_cyc.size());
        end else begin
            s = first + 3;
            for (int i = 0; i < 12; i++) begin
                vectors++;
                if (log_cyc[i] != s || log_dat[i] !== bytes[i]) begin
                    miscompares++;
                    $display("FAIL wrap_byte[%0d]: got cyc %0d data %h expected cyc %0d data %h",
                             i, log_cyc[i], log_dat[i], s, bytes[i]);
                end
                s = s + lat + 2;
            end
        end
        tx_lat = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stray();
        test_timeout();
        test_reset_busy();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete within budget");
        $fatal(1, "bench timeout");
    end

endmodule
